// File: rtl/vending_machine.sv
// Coin-operated vending controller: accumulates coin credit, pulses product_out
// for one cycle per completed purchase and carries any overpayment forward.
module vending_machine #(
    parameter int PRICE    = 15,
    parameter int COIN_A   = 5,
    parameter int COIN_B   = 10,
    parameter int CREDIT_W = 5   // must hold PRICE-1+max(COIN_A,COIN_B)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] coin_in,
    output logic       product_out
);

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_LO   = 2'b01,
        COIN_HI   = 2'b10,
        COIN_BAD  = 2'b11
    } coin_e;

    localparam logic [CREDIT_W:0] PRICE_S  = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0] COIN_A_S = (CREDIT_W+1)'(COIN_A);
    localparam logic [CREDIT_W:0] COIN_B_S = (CREDIT_W+1)'(COIN_B);

    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;
    logic                vend_nxt;

    // One extra bit on the sum so credit plus the largest coin cannot wrap.
    always_comb begin
        coin_val   = '0;
        sum        = '0;
        vend_nxt   = 1'b0;
        credit_nxt = credit;
        case (coin_e'(coin_in))
            COIN_LO:   coin_val = COIN_A_S;
            COIN_HI:   coin_val = COIN_B_S;
            default:   coin_val = '0;
        endcase
        sum = {1'b0, credit} + coin_val;
        if (sum >= PRICE_S) begin
            vend_nxt   = 1'b1;
            credit_nxt = CREDIT_W'(sum - PRICE_S);
        end else begin
            credit_nxt = CREDIT_W'(sum);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            credit      <= '0;
            product_out <= 1'b0;
        end else begin
            credit      <= credit_nxt;
            product_out <= vend_nxt;
        end
    end

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine: directed vector table, hand-written
// reset corner cases, and randomized traffic against a credit-arithmetic model.
module tb_vending_machine;

    logic       clk;
    logic       rst;
    logic [1:0] coin_in;
    logic       product_out;

    int n_cmp = 0;
    int n_err = 0;

    vending_machine dut (
        .clk         (clk),
        .rst         (rst),
        .coin_in     (coin_in),
        .product_out (product_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] coin;
        logic       exp_prod;
        int         exp_credit;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, take one rising edge, sample 1ns later.
    task automatic step(input logic r, input logic [1:0] c);
        rst     = r;
        coin_in = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [1:0] c, input logic p, input int cr);
        vec_t v;
        v.rst = r; v.coin = c; v.exp_prod = p; v.exp_credit = cr;
        vecs.push_back(v);
    endtask

    // Reference: credit arithmetic straight from the purchase rules.
    int m_credit;
    int m_prod;
    task automatic model(input logic r, input logic [1:0] c);
        int v;
        int s;
        if (!r) begin
            m_credit = 0;
            m_prod   = 0;
        end else begin
            v = (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0;
            s = m_credit + v;
            if (s >= 15) begin
                m_prod   = 1;
                m_credit = s - 15;
            end else begin
                m_prod   = 0;
                m_credit = s;
            end
        end
    endtask

    initial begin
        rst     = 1'b0;
        coin_in = 2'b00;

        // reset held two edges with a coin present
        add(0, 2'b10, 0, 0);
        add(0, 2'b10, 0, 0);
        add(1, 2'b00, 0, 0);
        // exact price
        add(1, 2'b01, 0, 5);
        add(1, 2'b01, 0, 10);
        add(1, 2'b01, 1, 0);
        add(1, 2'b00, 0, 0);
        // overpay carry, then finish with two small coins
        add(1, 2'b10, 0, 10);
        add(1, 2'b10, 1, 5);
        add(1, 2'b01, 0, 10);
        add(1, 2'b01, 1, 0);
        // invalid code held
        add(1, 2'b01, 0, 5);
        for (int i = 0; i < 5; i++) add(1, 2'b11, 0, 5);
        add(1, 2'b10, 1, 0);
        add(1, 2'b00, 0, 0);
        // held level counts per cycle
        add(1, 2'b01, 0, 5);
        add(1, 2'b01, 0, 10);
        add(1, 2'b01, 1, 0);
        add(1, 2'b01, 0, 5);
        add(1, 2'b01, 0, 10);
        add(1, 2'b01, 1, 0);
        add(1, 2'b00, 0, 0);
        // back-to-back purchases
        add(1, 2'b10, 0, 10);
        add(1, 2'b10, 1, 5);
        add(1, 2'b10, 1, 0);
        add(1, 2'b00, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].coin);
            check($sformatf("vec%0d product_out", i), int'(product_out), int'(vecs[i].exp_prod));
            check($sformatf("vec%0d credit", i), int'(dut.credit), vecs[i].exp_credit);
        end

        // mid-purchase reset discards credit
        step(1, 2'b10);
        check("midrst pre credit", int'(dut.credit), 10);
        step(0, 2'b00);
        check("midrst reset prod", int'(product_out), 0);
        check("midrst reset credit", int'(dut.credit), 0);
        step(1, 2'b01);
        check("midrst after prod", int'(product_out), 0);
        check("midrst after credit", int'(dut.credit), 5);

        // reset overrides a coin that would complete a purchase
        step(1, 2'b01);
        check("ovr pre credit", int'(dut.credit), 10);
        step(0, 2'b10);
        check("ovr reset prod", int'(product_out), 0);
        check("ovr reset credit", int'(dut.credit), 0);

        // randomized traffic vs model
        m_credit = 0;
        m_prod   = 0;
        for (int i = 0; i < 2000; i++) begin
            logic       r;
            logic [1:0] c;
            r = ($urandom_range(0, 31) != 0);
            c = 2'($urandom_range(0, 3));
            model(r, c);
            step(r, c);
            check($sformatf("rnd%0d product_out", i), int'(product_out), m_prod);
            check($sformatf("rnd%0d credit", i), int'(dut.credit), m_credit);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
